// File: rtl/imm_rotate_encoder_pkg.sv
// Shared state codes, rotation constants and result type for the immediate rotate encoder.
// The `define block is guarded so this file can be pulled into any compilation unit.
`ifndef IMMENC_DEFS_SVH
`define IMMENC_DEFS_SVH
`define IMMENC_IDLE   2'd0
`define IMMENC_SEARCH 2'd1
`define IMMENC_DONE   2'd2
`define ROT_STEP      2
`define ROT_MAX       15
`endif

package imm_rotate_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `IMMENC_IDLE,
    ST_SEARCH = `IMMENC_SEARCH,
    ST_DONE   = `IMMENC_DONE
  } state_e;

  localparam int unsigned ROT_STEP = `ROT_STEP;
  localparam logic [3:0]  ROT_MAX  = 4'(`ROT_MAX);

  typedef struct packed {
    logic       valid;
    logic       inverted;
    logic [3:0] rot;
    logic [7:0] imm8;
  } enc_result_t;

  // One search step: rotate left by the architectural rotation granule.
  function automatic logic [31:0] rol_step(input logic [31:0] x);
    return (x << ROT_STEP) | (x >> (32 - ROT_STEP));
  endfunction

endpackage

// File: rtl/imm_rotate_encoder_fit.sv
// Combinational fit test: a rotated word is encodable when only its low byte is non-zero.
module imm_fit_check (
  input  logic [31:0] work,
  output logic        fit,
  output logic [7:0]  imm8
);

  assign fit  = (work[31:8] == 24'd0);
  assign imm8 = work[7:0];

endmodule

// File: rtl/imm_rotate_encoder.sv
// Iterative encoder: finds {rotate_imm, imm8} with value == ROR(imm8, 2*rotate_imm),
// one rotation per cycle, optionally retrying on ~value for the MVN form.
module imm_rotate_encoder
  import imm_rotate_encoder_pkg::*;
#(
  parameter bit INVERT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic        inverted,
  output logic [3:0]  rotate_imm,
  output logic [7:0]  imm8,
  output logic [11:0] shifter_operand
);

  state_e      state_q, state_d;
  logic [31:0] work_q, work_d;
  logic [31:0] value_q, value_d;
  logic [3:0]  r_q, r_d;
  logic        pass_q, pass_d;
  enc_result_t res_q, res_d;

  logic        fit;
  logic [7:0]  fit_imm8;
  logic        last_rot;
  logic        retry;

  imm_fit_check u_fit (
    .work (work_q),
    .fit  (fit),
    .imm8 (fit_imm8)
  );

  assign last_rot = (r_q == ROT_MAX);
  // Retry reloads ~value on the same edge as the final miss, so pass 1 starts without a gap.
  assign retry    = last_rot && INVERT_EN && !pass_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (fit || (last_rot && !retry)) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_SEARCH: busy = 1'b1;
      ST_DONE:   done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath next-value logic
  always_comb begin
    work_d  = work_q;
    value_d = value_q;
    r_d     = r_q;
    pass_d  = pass_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          work_d  = value;
          value_d = value;
          r_d     = 4'd0;
          pass_d  = 1'b0;
          res_d   = '0;
        end
      end
      ST_SEARCH: begin
        if (fit) begin
          res_d.valid    = 1'b1;
          res_d.inverted = pass_q;
          res_d.rot      = r_q;
          res_d.imm8     = fit_imm8;
        end else if (!last_rot) begin
          work_d = rol_step(work_q);
          r_d    = r_q + 4'd1;
        end else if (retry) begin
          work_d = ~value_q;
          r_d    = 4'd0;
          pass_d = 1'b1;
        end else begin
          res_d = '0;
        end
      end
      default: begin
        work_d = work_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q  <= '0;
      value_q <= '0;
      r_q     <= '0;
      pass_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      work_q  <= work_d;
      value_q <= value_d;
      r_q     <= r_d;
      pass_q  <= pass_d;
      res_q   <= res_d;
    end
  end

  assign valid           = res_q.valid;
  assign inverted        = res_q.inverted;
  assign rotate_imm      = res_q.rot;
  assign imm8            = res_q.imm8;
  assign shifter_operand = {res_q.rot, res_q.imm8};

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Bench: two encoders (INVERT_EN=1 at index 0, INVERT_EN=0 at index 1) share stimulus;
// a brute-force search over every (rot, imm8) pair predicts results and done timing.
module tb_imm_rotate_encoder;

  typedef struct packed {
    logic       valid;
    logic       inverted;
    logic [3:0] rot;
    logic [7:0] imm8;
  } res_t;

  typedef struct packed {
    res_t       r;
    logic [7:0] lat;
  } enc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;

  logic        busy_w  [2];
  logic        done_w  [2];
  logic        valid_w [2];
  logic        inv_w   [2];
  logic [3:0]  rot_w   [2];
  logic [7:0]  imm_w   [2];
  logic [11:0] so_w    [2];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        rst_edge = 1'b1;

  bit          have_txn = 1'b0;
  int          n_start = 0;
  logic [31:0] cap_val = '0;
  enc_t        cur  [2];
  res_t        prev [2];

  imm_rotate_encoder #(.INVERT_EN(1'b1)) u_dut_inv (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_w[0]), .done(done_w[0]), .valid(valid_w[0]), .inverted(inv_w[0]),
    .rotate_imm(rot_w[0]), .imm8(imm_w[0]), .shifter_operand(so_w[0])
  );

  imm_rotate_encoder #(.INVERT_EN(1'b0)) u_dut_pos (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_w[1]), .done(done_w[1]), .valid(valid_w[1]), .inverted(inv_w[1]),
    .rotate_imm(rot_w[1]), .imm8(imm_w[1]), .shifter_operand(so_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: exhaustive search in priority order (pass, then rotation); latency from position.
  function automatic enc_t model(input logic [31:0] v, input bit inv_en);
    enc_t        e;
    logic [31:0] tgt;
    e     = '0;
    e.lat = inv_en ? 8'd33 : 8'd17;
    for (int p = 0; p < 2; p++) begin
      if (p == 1 && !inv_en) break;
      tgt = (p == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        for (int i = 0; i < 256; i++) begin
          if (ror32(32'(i), 2 * r) == tgt) begin
            e.r.valid    = 1'b1;
            e.r.inverted = (p == 1);
            e.r.rot      = 4'(r);
            e.r.imm8     = 8'(i);
            e.lat        = 8'(2 + r + 16 * p);
            return e;
          end
        end
      end
    end
    return e;
  endfunction

  // Per-cycle compare of both DUTs against the expected timeline.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      res_t        er;
      res_t        got;
      logic        eb;
      logic        ed;
      int          lat;
      logic [31:0] tgt;
      er  = '0;
      eb  = 1'b0;
      ed  = 1'b0;
      lat = int'(cur[d].lat);
      if (rst_edge || !have_txn) begin
        er = '0;
      end else if (cyc <= n_start) begin
        er = prev[d];
      end else if (cyc < n_start + lat) begin
        eb = 1'b1;
      end else if (cyc == n_start + lat) begin
        ed = 1'b1;
        er = cur[d].r;
      end else begin
        er = cur[d].r;
      end
      got = {valid_w[d], inv_w[d], rot_w[d], imm_w[d]};
      total++;
      if (got !== er || busy_w[d] !== eb || done_w[d] !== ed || so_w[d] !== {er.rot, er.imm8}) begin
        bad++;
        $display("FAIL cycle_check dut=%0d cyc=%0d got busy=%b done=%b res=%h so=%h need busy=%b done=%b res=%h so=%h",
                 d, cyc, busy_w[d], done_w[d], got, so_w[d], eb, ed, er, {er.rot, er.imm8});
      end
      if (done_w[d] === 1'b1 && valid_w[d] === 1'b1) begin
        tgt = inv_w[d] ? ~cap_val : cap_val;
        total++;
        if (ror32({24'd0, imm_w[d]}, 2 * int'(rot_w[d])) !== tgt) begin
          bad++;
          $display("FAIL ror_identity dut=%0d got ror=%h need %h", d,
                   ror32({24'd0, imm_w[d]}, 2 * int'(rot_w[d])), tgt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input logic [31:0] v, input bit inv_en,
                     input logic ev, input logic ei, input logic [3:0] er,
                     input logic [7:0] eimm, input int elat);
    enc_t e;
    e = model(v, inv_en);
    total++;
    if (e.r.valid !== ev || e.r.inverted !== ei || e.r.rot !== er ||
        e.r.imm8 !== eimm || int'(e.lat) != elat) begin
      bad++;
      $display("FAIL pin_%s got v=%b i=%b rot=%0d imm=%h lat=%0d need v=%b i=%b rot=%0d imm=%h lat=%0d",
               name, e.r.valid, e.r.inverted, e.r.rot, e.r.imm8, e.lat, ev, ei, er, eimm, elat);
    end
  endtask

  // Called at posedge+2 with both DUTs idle.
  task automatic run_txn(input logic [31:0] v, input bit extra, input int abort_after);
    int lmax;
    int lmin;
    int k;
    for (int d = 0; d < 2; d++) begin
      prev[d] = have_txn ? cur[d].r : '0;
      cur[d]  = model(v, d == 0);
    end
    cap_val  = v;
    n_start  = cyc;
    have_txn = 1'b1;
    start    = 1'b1;
    value    = v;
    $display("txn value=%h inv_en1: v=%b i=%b rot=%0d imm=%h lat=%0d | inv_en0: v=%b rot=%0d imm=%h lat=%0d extra=%0d abort=%0d",
             v, cur[0].r.valid, cur[0].r.inverted, cur[0].r.rot, cur[0].r.imm8, cur[0].lat,
             cur[1].r.valid, cur[1].r.rot, cur[1].r.imm8, cur[1].lat, extra, abort_after);
    step();
    start = 1'b0;
    value = $urandom();
    lmax  = (cur[0].lat > cur[1].lat) ? int'(cur[0].lat) : int'(cur[1].lat);
    lmin  = (cur[0].lat < cur[1].lat) ? int'(cur[0].lat) : int'(cur[1].lat);
    if (abort_after > 0) begin
      repeat (abort_after - 1) step();
      rst = 1'b1;
      step();
      step();
      rst      = 1'b0;
      have_txn = 1'b0;
      step();
      return;
    end
    if (extra) begin
      k = int'($urandom_range(32'(lmin - 1), 0));
      repeat (k) step();
      start = 1'b1;
      value = $urandom();
      step();
      start = 1'b0;
    end
    while (cyc < n_start + lmax + 1) step();
    repeat ($urandom_range(2, 0)) step();
  endtask

  function automatic logic [31:0] rand_value();
    logic [31:0] b;
    b = ror32({24'd0, 8'($urandom())}, 2 * int'($urandom_range(15, 0)));
    case ($urandom_range(4, 0))
      0: return $urandom();
      1: return b;
      2: return ~b;
      3: return ror32({24'd0, 8'($urandom())}, int'($urandom_range(31, 0)));
      default: return ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFFF : 32'h0;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d need completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      cur[d]  = '0;
      prev[d] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    pin("ff",       32'h0000_00FF, 1'b1, 1'b1, 1'b0, 4'd0,  8'hFF, 2);
    pin("ff000000", 32'hFF00_0000, 1'b1, 1'b1, 1'b0, 4'd4,  8'hFF, 6);
    pin("104",      32'h0000_0104, 1'b1, 1'b1, 1'b0, 4'd15, 8'h41, 17);
    pin("f000000f", 32'hF000_000F, 1'b0, 1'b1, 1'b0, 4'd2,  8'hFF, 4);
    pin("ffffff00", 32'hFFFF_FF00, 1'b1, 1'b1, 1'b1, 4'd0,  8'hFF, 18);
    pin("101_inv",  32'h0000_0101, 1'b1, 1'b0, 1'b0, 4'd0,  8'h00, 33);
    pin("101_pos",  32'h0000_0101, 1'b0, 1'b0, 1'b0, 4'd0,  8'h00, 17);
    pin("zero",     32'h0000_0000, 1'b1, 1'b1, 1'b0, 4'd0,  8'h00, 2);

    run_txn(32'h0000_00FF, 1'b0, 0);
    run_txn(32'hFF00_0000, 1'b0, 0);
    run_txn(32'h0000_0104, 1'b0, 0);
    run_txn(32'hF000_000F, 1'b0, 0);
    run_txn(32'hFFFF_FF00, 1'b0, 0);
    run_txn(32'h0000_0101, 1'b0, 0);
    run_txn(32'h0000_0000, 1'b0, 0);
    run_txn(32'h0000_0101, 1'b0, 5);
    run_txn(32'hFF00_0000, 1'b1, 0);
    run_txn(32'h0000_0104, 1'b1, 0);

    for (int t = 0; t < 150; t++) begin
      run_txn(rand_value(), ($urandom_range(3, 0) == 0), 0);
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
